// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit: initiator side of the instruction-memory read
//   interface. Keeps the program counter, presents it as the word address to
//   instr_mem, captures the combinational read data on the same edge that
//   advances the PC, and hands {pc, instr} pairs to decode through a 2-entry
//   FIFO with a valid/ready handshake. Redirects flush the FIFO and reload the
//   PC; a fetched HALT_INSTR word stops fetching until the next redirect.
//
// Parameters
//   RESET_PC   : PC value after reset (word address)
//   PC_STEP    : PC increment per fetch
//   HALT_INSTR : encoding that stops fetching
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   fetch_en       : allow fetching
//   imem_addr      : word address to instr_mem (registered PC)
//   imem_data      : combinational read data for imem_addr
//   redirect_valid : branch/jump taken this cycle
//   redirect_pc    : redirect target word address
//   instr_valid    : FIFO head holds an instruction
//   instr_ready    : decode accepts the head
//   instr_out      : head instruction
//   instr_pc       : address the head was fetched from
//   halted         : high while in HALTED state
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic        halted_q;
  logic [31:0] pc_q;

  // Two-entry FIFO storage, addressed by one-bit read/write pointers.
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic pop;
  logic push;
  logic flush;
  logic is_halt;

  assign instr_valid = (count != 2'd0);
  assign instr_out   = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];
  assign imem_addr   = pc_q;
  assign halted      = halted_q;

  assign pop     = instr_valid & instr_ready;
  // Redirect is ignored in IDLE; elsewhere it outranks everything else.
  assign flush   = redirect_valid & (state_q != S_IDLE);
  // A full FIFO can still accept a fetch when the head leaves this cycle.
  assign push    = (state_q == S_RUN) & fetch_en & ~redirect_valid &
                   ((count < 2'd2) | pop);
  assign is_halt = (imem_data == HALT_INSTR);

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values of the others, matching hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      halted_q <= 1'b0;
      pc_q     <= RESET_PC;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      // NOTE: the FIFO storage is reset too, because its head drives
      // instr_out/instr_pc directly and those must read zero after reset.
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= 32'h0;
      end
    end else if (flush) begin
      // Flush drops both buffered entries and any pop this cycle; no fetch.
      state_q  <= S_RUN;
      halted_q <= 1'b0;
      pc_q     <= redirect_pc;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]    <= pc_q;
        buf_instr[wr_ptr] <= imem_data;
        wr_ptr            <= ~wr_ptr;
        // The halt word is enqueued but the PC parks on it.
        if (!is_halt) begin
          pc_q <= pc_q + PC_STEP;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};

      case (state_q)
        S_IDLE: begin
          if (fetch_en) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!fetch_en) begin
            state_q <= S_IDLE;
          end else if (push && is_halt) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: begin
          // Only a redirect (handled above) leaves HALTED.
          state_q <= S_HALTED;
        end
        default: begin
          state_q  <= S_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. instr_mem is modelled as
//   addr ^ 32'hA5A5_0000, with addr 5 returning the halt word when halt_en is
//   set. A table of per-cycle vectors covers start-up streaming and
//   backpressure; hand-written sequences cover redirect flush, halt/resume,
//   PC wrap and asynchronous reset. Every delivered instruction is compared
//   against a scoreboard queue filled from the expected fetch order.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        halted;
  logic        halt_en;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
  entry_t sb_q[$];

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[15];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
    if (h && a == 32'd5) return HALT;
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb imem_data = mem_word(imem_addr, halt_en);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled at negedge, where valid/ready reflect the
  // upcoming rising edge. Redirect cycles drop the pop.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 &&
        redirect_valid === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc %h instr %h expected none",
                 instr_pc, instr_out);
      end else begin
        entry_t e;
        e = sb_q.pop_front();
        check("deliver_pc", instr_pc, e.pc);
        check("deliver_instr", instr_out, e.instr);
      end
    end
  end

  // Drive one cycle of inputs, let one rising edge happen, sample #1 after it.
  task automatic step(input logic fe, input logic rdy,
                      input logic rv = 1'b0, input logic [31:0] rpc = 32'h0);
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] addr, input logic h);
    check({tag, "_valid"}, {31'h0, instr_valid}, {31'h0, v});
    check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_halted"}, {31'h0, halted}, {31'h0, h});
    if (v) begin
      check({tag, "_pc"}, instr_pc, pc);
      check({tag, "_instr"}, instr_out, mem_word(pc, halt_en));
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = mem_word(pc, halt_en);
    sb_q.push_back(e);
  endtask

  task automatic expect_drained(input string tag);
    check({tag, "_sb_left"}, sb_q.size(), 32'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Per-cycle table: inputs for the edge, outputs expected after it.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'd0, 32'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'd1, 32'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'd2, 32'd3};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'd3, 32'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd5};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd5};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd5};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd3, 32'd5};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'd4, 32'd6};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'd5, 32'd7};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'd6, 32'd7};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd7};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd7};

    halt_en        = 1'b0;
    fetch_en       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'h0, instr_valid}, 32'd0);
    check("reset_instr_out", instr_out, 32'h0);
    check("reset_instr_pc", instr_pc, 32'h0);
    check("reset_addr", imem_addr, 32'h0);
    check("reset_halted", {31'h0, halted}, 32'd0);
    rst_n = 1'b1;

    // Streaming start-up, backpressure saturation, release, drop to IDLE.
    for (int i = 0; i <= 6; i++) expect_fetch(i);
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].fe, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].addr, 1'b0);
    end
    expect_drained("stream");

    // Fill FIFO without draining, then redirect: buffered 7 and 8 vanish.
    step(1, 0);
    step(1, 0);
    step(1, 0);
    step(1, 0);
    expect_out("full", 1'b1, 32'd7, 32'd9, 1'b0);
    step(1, 1, 1'b1, 32'h0000_0018);
    expect_out("redir", 1'b0, 32'd0, 32'd24, 1'b0);
    for (int i = 24; i <= 26; i++) expect_fetch(i);
    step(1, 1);
    expect_out("redir_first", 1'b1, 32'd24, 32'd25, 1'b0);
    step(1, 1);
    step(1, 1);
    step(0, 1);
    step(0, 1);
    expect_drained("redirect");

    // Halt word at address 5, then resume via redirect to 0x111.
    do_reset;
    halt_en = 1'b1;
    for (int i = 0; i <= 5; i++) expect_fetch(i);
    step(1, 1);
    for (int i = 0; i < 6; i++) step(1, 1);
    expect_out("halt_fetched", 1'b1, 32'd5, 32'd5, 1'b1);
    step(0, 1);
    expect_out("halt_drain", 1'b0, 32'd0, 32'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1);
      expect_out($sformatf("halt_hold%0d", i), 1'b0, 32'd0, 32'd5, 1'b1);
    end
    step(1, 1, 1'b1, 32'h0000_0111);
    expect_out("resume", 1'b0, 32'd0, 32'd273, 1'b0);
    expect_fetch(273);
    expect_fetch(274);
    step(1, 1);
    expect_out("resume_first", 1'b1, 32'd273, 32'd274, 1'b0);
    step(1, 1);
    step(0, 1);
    step(0, 1);
    expect_drained("halt");

    // PC wrap from 0xFFFF_FFFF to 0.
    halt_en = 1'b0;
    step(1, 1);
    step(1, 1, 1'b1, 32'hFFFF_FFFF);
    expect_out("wrap_redir", 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    expect_fetch(32'hFFFF_FFFF);
    expect_fetch(32'h0);
    step(1, 1);
    expect_out("wrap_top", 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step(1, 1);
    expect_out("wrap_zero", 1'b1, 32'd0, 32'd1, 1'b0);
    step(0, 1);
    step(0, 1);
    expect_drained("wrap");

    // Asynchronous reset with a full FIFO.
    step(1, 0);
    step(1, 0);
    step(1, 0);
    expect_out("prereset_full", 1'b1, 32'd1, 32'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'h0, instr_valid}, 32'd0);
    check("async_addr", imem_addr, 32'h0);
    check("async_instr_out", instr_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0);
    step(0, 0);
    expect_out("post_reset_idle", 1'b0, 32'd0, 32'd0, 1'b0);
    expect_fetch(0);
    step(1, 1);
    expect_out("post_reset_run", 1'b0, 32'd0, 32'd0, 1'b0);
    step(1, 1);
    expect_out("post_reset_first", 1'b1, 32'd0, 32'd1, 1'b0);
    step(0, 1);
    step(0, 1);
    expect_drained("reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
